// File: rtl/msu_pkg.sv
// Shared types and size arithmetic for the MSU audio streamer.
package msu_pkg;

  typedef enum logic [2:0] {IDLE, MOUNT, REQ, XFER, NEXT} state_t;

  localparam int BYTES_PER_SAMPLE = 4;

  typedef struct packed {
    logic [63:0] end_frame;
    logic [63:0] tail_bytes;
  } size_info_t;

  // end_frame = ceil(size / sector) - 1; tail_bytes = size mod sector (0 = full sector)
  function automatic size_info_t calc_size(input logic [63:0] size, input int slog2);
    size_info_t r;
    logic [63:0] m;
    m            = (64'd1 << slog2) - 64'd1;
    r.end_frame  = ((size + m) >> slog2) - 64'd1;
    r.tail_bytes = size & m;
    return r;
  endfunction

endpackage

// File: rtl/msu_word_gate.sv
// Forwards a sector word to the FIFO one cycle after its strobe when its
// index falls inside the window [lo, hi).
module msu_word_gate #(
  parameter int IDX_W  = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              strobe_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [IDX_W-1:0]  lo_i,
  input  logic [IDX_W-1:0]  hi_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              wr_o,
  output logic [DATA_W-1:0] data_o
);

  logic              wr_d, wr_q;
  logic [DATA_W-1:0] data_q;

  assign wr_d = strobe_i && (idx_i >= lo_i) && (idx_i < hi_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q   <= 1'b0;
      data_q <= '0;
    end else begin
      wr_q <= wr_d;
      if (wr_d) data_q <= din_i;
    end
  end

  assign wr_o   = wr_q;
  assign data_o = data_q;

endmodule

// File: rtl/msu_audio_streamer.sv
// Streams an MSU audio track from SD sectors into the audio FIFO with tail
// trimming, sample-accurate looping, stop and back-pressure.
// Optional MSU_LOOP_COUNT_EN adds a saturating loop_count output.
module msu_audio_streamer import msu_pkg::*; #(
  parameter int SECTOR_LOG2 = 9,
  parameter int DATA_W      = 16,
  parameter int LBA_W       = 21,
  parameter int SIZE_W      = 32,
  parameter int LVL_W       = 11,
  parameter int FIFO_HIGH   = 1792
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trig_play,
  input  logic              repeat_en,
  input  logic [31:0]       loop_sample,
  input  logic [SIZE_W-1:0] img_size,
  input  logic              track_ready,
  input  logic              stop,
  output logic [LBA_W-1:0]  sd_lba,
  output logic              sd_rd,
  input  logic              sd_ack,
  input  logic              sd_buff_wr,
  input  logic [DATA_W-1:0] sd_buff_dout,
  output logic              fifo_wr,
  output logic [DATA_W-1:0] fifo_data,
  input  logic [LVL_W-1:0]  fifo_usedw,
  output logic              playing,
  output logic              track_end
`ifdef MSU_LOOP_COUNT_EN
  , output logic [7:0]      loop_count
`endif
);

  localparam int BPW      = DATA_W / 8;
  localparam int BPW_LOG2 = $clog2(BPW);
  localparam int WI_W     = SECTOR_LOG2 + 1;
  localparam logic [WI_W-1:0] WPS       = WI_W'((1 << SECTOR_LOG2) / BPW);
  localparam logic [63:0]     SIZE_MASK = (64'd1 << (LBA_W + SECTOR_LOG2)) - 64'd1;
  localparam logic [63:0]     SEC_MASK  = (64'd1 << SECTOR_LOG2) - 64'd1;

  state_t            state_d, state_q;
  logic [LBA_W-1:0]  frame_d, frame_q, end_frame_d, end_frame_q, loop_frame_d, loop_frame_q;
  logic [WI_W-1:0]   tail_d, tail_q, loop_word_d, loop_word_q, widx_d, widx_q;
  logic              repeat_d, repeat_q, wrap_d, wrap_q, drain_d, drain_q;
  logic              restart_d, restart_q, playing_d, playing_q, track_end_d, track_end_q;
`ifdef MSU_LOOP_COUNT_EN
  logic [7:0]        lc_d, lc_q;
`endif

  // Track geometry derived from the live inputs, latched on trig_play
  logic [63:0]       size_m, loop_byte, lf_full;
  size_info_t        si;
  logic              loop_ok, size_zero;
  logic [LBA_W-1:0]  end_frame_c, loop_frame_c;
  logic [WI_W-1:0]   tail_c, loop_word_c;

  always_comb begin
    size_m       = 64'(img_size) & SIZE_MASK;
    size_zero    = (size_m == 64'd0);
    si           = calc_size(size_m, SECTOR_LOG2);
    loop_byte    = 64'(loop_sample) * 64'(BYTES_PER_SAMPLE);
    lf_full      = loop_byte >> SECTOR_LOG2;
    loop_ok      = (lf_full <= si.end_frame);
    end_frame_c  = si.end_frame[LBA_W-1:0];
    tail_c       = WI_W'(si.tail_bytes >> BPW_LOG2);
    loop_frame_c = loop_ok ? lf_full[LBA_W-1:0] : '0;
    loop_word_c  = loop_ok ? WI_W'((loop_byte & SEC_MASK) >> BPW_LOG2) : '0;
  end

  // REQ with sd_ack already high behaves as the first cycle of the transfer
  logic in_xfer;
  assign in_xfer = (state_q == XFER) || (state_q == REQ && sd_ack);

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    end_frame_d  = end_frame_q;
    tail_d       = tail_q;
    loop_frame_d = loop_frame_q;
    loop_word_d  = loop_word_q;
    repeat_d     = repeat_q;
    wrap_d       = wrap_q;
    widx_d       = widx_q;
    drain_d      = drain_q;
    restart_d    = restart_q;
    playing_d    = playing_q;
    track_end_d  = 1'b0;
`ifdef MSU_LOOP_COUNT_EN
    lc_d         = lc_q;
`endif
    if (in_xfer && sd_buff_wr) widx_d = widx_q + 1'b1;

    if (trig_play) begin
      frame_d      = '0;
      wrap_d       = 1'b0;
      end_frame_d  = end_frame_c;
      tail_d       = tail_c;
      loop_frame_d = loop_frame_c;
      loop_word_d  = loop_word_c;
      repeat_d     = repeat_en;
      playing_d    = !size_zero;
      track_end_d  = size_zero;
`ifdef MSU_LOOP_COUNT_EN
      lc_d         = 8'd0;
`endif
      if (in_xfer) begin
        // finish the in-flight sector silently, then restart
        state_d   = XFER;
        drain_d   = 1'b1;
        restart_d = !size_zero;
      end else begin
        state_d   = size_zero ? IDLE : MOUNT;
        drain_d   = 1'b0;
        restart_d = 1'b0;
        widx_d    = '0;
      end
    end else if (stop) begin
      playing_d = 1'b0;
      restart_d = 1'b0;
      if (in_xfer) begin
        state_d = XFER;
        drain_d = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        MOUNT: if (track_ready) begin
          state_d = REQ;
          widx_d  = '0;
        end
        REQ: if (sd_ack) state_d = XFER;
        XFER: if (!sd_ack) begin
          widx_d    = '0;
          wrap_d    = 1'b0;
          drain_d   = 1'b0;
          restart_d = 1'b0;
          state_d   = drain_q ? (restart_q ? MOUNT : IDLE) : NEXT;
        end
        NEXT: if (fifo_usedw < LVL_W'(FIFO_HIGH)) begin
          if (frame_q < end_frame_q) begin
            frame_d = frame_q + 1'b1;
            state_d = REQ;
          end else if (repeat_q) begin
            frame_d = loop_frame_q;
            wrap_d  = 1'b1;
            state_d = REQ;
`ifdef MSU_LOOP_COUNT_EN
            if (lc_q != 8'hFF) lc_d = lc_q + 8'd1;
`endif
          end else begin
            playing_d   = 1'b0;
            track_end_d = 1'b1;
            state_d     = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      frame_q      <= '0;
      end_frame_q  <= '0;
      tail_q       <= '0;
      loop_frame_q <= '0;
      loop_word_q  <= '0;
      repeat_q     <= 1'b0;
      wrap_q       <= 1'b0;
      widx_q       <= '0;
      drain_q      <= 1'b0;
      restart_q    <= 1'b0;
      playing_q    <= 1'b0;
      track_end_q  <= 1'b0;
`ifdef MSU_LOOP_COUNT_EN
      lc_q         <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      end_frame_q  <= end_frame_d;
      tail_q       <= tail_d;
      loop_frame_q <= loop_frame_d;
      loop_word_q  <= loop_word_d;
      repeat_q     <= repeat_d;
      wrap_q       <= wrap_d;
      widx_q       <= widx_d;
      drain_q      <= drain_d;
      restart_q    <= restart_d;
      playing_q    <= playing_d;
      track_end_q  <= track_end_d;
`ifdef MSU_LOOP_COUNT_EN
      lc_q         <= lc_d;
`endif
    end
  end

  // Window: skip pre-loop words after a wrap, trim past the tail on the last frame
  logic [WI_W-1:0] lo_c, hi_c;
  logic            fwd_c;
  assign lo_c  = wrap_q ? loop_word_q : '0;
  assign hi_c  = (frame_q == end_frame_q && tail_q != '0) ? tail_q : WPS;
  assign fwd_c = in_xfer && sd_buff_wr && !drain_q && !stop && !trig_play;

  msu_word_gate #(.IDX_W(WI_W), .DATA_W(DATA_W)) u_gate (
    .clk      (clk),
    .reset_n  (reset_n),
    .strobe_i (fwd_c),
    .idx_i    (widx_q),
    .lo_i     (lo_c),
    .hi_i     (hi_c),
    .din_i    (sd_buff_dout),
    .wr_o     (fifo_wr),
    .data_o   (fifo_data)
  );

  assign sd_lba    = frame_q;
  assign sd_rd     = (state_q == REQ) && !sd_ack;
  assign playing   = playing_q;
  assign track_end = track_end_q;
`ifdef MSU_LOOP_COUNT_EN
  assign loop_count = lc_q;
`endif

endmodule

// File: tb/tb_msu_audio_streamer.sv
// Directed bench for msu_audio_streamer: an SD sector responder plus a FIFO
// monitor, one task per scenario.
module tb_msu_audio_streamer;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        trig_play = 1'b0, repeat_en = 1'b0, track_ready = 1'b1, stop = 1'b0;
  logic        sd_ack = 1'b0, sd_buff_wr = 1'b0;
  logic [31:0] loop_sample = '0, img_size = '0;
  logic [15:0] sd_buff_dout = '0;
  logic [10:0] fifo_usedw = '0;
  logic [20:0] sd_lba;
  logic        sd_rd, fifo_wr, playing, track_end;
  logic [15:0] fifo_data;
`ifdef MSU_LOOP_COUNT_EN
  logic [7:0]  loop_count;
`endif

  int compared = 0, mismatched = 0;
  int wr_cnt = 0, te_cnt = 0;
  logic [15:0] wr_log[$];

  msu_audio_streamer dut (
    .clk(clk), .reset_n(reset_n), .trig_play(trig_play), .repeat_en(repeat_en),
    .loop_sample(loop_sample), .img_size(img_size), .track_ready(track_ready),
    .stop(stop), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_ack(sd_ack),
    .sd_buff_wr(sd_buff_wr), .sd_buff_dout(sd_buff_dout), .fifo_wr(fifo_wr),
    .fifo_data(fifo_data), .fifo_usedw(fifo_usedw), .playing(playing),
    .track_end(track_end)
`ifdef MSU_LOOP_COUNT_EN
    , .loop_count(loop_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_wr) begin
      wr_cnt++;
      wr_log.push_back(fifo_data);
    end
    if (track_end) te_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_trig(input logic [31:0] size, input logic rep, input logic [31:0] ls);
    img_size = size; repeat_en = rep; loop_sample = ls;
    trig_play = 1'b1; tick(); trig_play = 1'b0;
  endtask

  // Wait (bounded) for a request, then deliver 256 words tagged {lba, index}
  task automatic sd_serve(input int stop_at, output logic [20:0] lba, output bit ok);
    int t;
    t = 0; ok = 1'b0; lba = '0;
    while (sd_rd !== 1'b1 && t < 3000) begin tick(); t++; end
    if (sd_rd !== 1'b1) return;
    ok = 1'b1; lba = sd_lba; sd_ack = 1'b1; tick();
    for (int w = 0; w < 256; w++) begin
      sd_buff_wr = 1'b1; sd_buff_dout = {lba[7:0], 8'(w)}; stop = (w == stop_at);
      tick();
    end
    sd_buff_wr = 1'b0; stop = 1'b0; tick();
    sd_ack = 1'b0; tick();
  endtask

  task automatic serve_expect(input string nm, input int exp_lba);
    logic [20:0] lba; bit ok;
    sd_serve(-1, lba, ok);
    compared++;
    if (!ok || lba !== 21'(exp_lba)) begin
      mismatched++;
      $display("FAIL %s: lba got %0d ok=%0d want %0d", nm, lba, ok, exp_lba);
    end
  endtask

  task automatic test_reset();
    tick(2);
    compared++;
    if ({sd_lba, sd_rd, fifo_wr, fifo_data, playing, track_end} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: lba=%0h rd=%0b wr=%0b data=%0h play=%0b te=%0b want all 0",
               sd_lba, sd_rd, fifo_wr, fifo_data, playing, track_end);
    end
    reset_n = 1'b1; tick();
  endtask

  task automatic test_full_track();
    int wb, tb;
    wb = wr_cnt; tb = te_cnt;
    do_trig(32'd2048, 1'b0, 32'd0);
    compared++;
    if (playing !== 1'b1) begin mismatched++; $display("FAIL full_playing: got %0b want 1", playing); end
    for (int i = 0; i < 4; i++) serve_expect("full_lba", i);
    tick(4);
    compared++;
    if (wr_cnt - wb !== 1024) begin mismatched++; $display("FAIL full_writes: got %0d want 1024", wr_cnt - wb); end
    compared++;
    if (te_cnt - tb !== 1) begin mismatched++; $display("FAIL full_track_end: got %0d want 1", te_cnt - tb); end
    compared++;
    if (playing !== 1'b0) begin mismatched++; $display("FAIL full_stopped: playing %0b want 0", playing); end
    if (wr_cnt - wb == 1024) begin
      compared++;
      if (wr_log[wb] !== 16'h0000 || wr_log[wb+1023] !== 16'h03FF) begin
        mismatched++;
        $display("FAIL full_data: first %0h last %0h want 0000 03ff", wr_log[wb], wr_log[wb+1023]);
      end
    end
  endtask

  task automatic test_partial_tail();
    int wb, w5;
    wb = wr_cnt;
    do_trig(32'd2660, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) serve_expect("tail_lba", i);
    w5 = wr_cnt;
    serve_expect("tail_lba", 5);
    tick(4);
    compared++;
    if (wr_cnt - w5 !== 50) begin mismatched++; $display("FAIL tail_words: got %0d want 50", wr_cnt - w5); end
    compared++;
    if (wr_cnt - wb !== 1330) begin mismatched++; $display("FAIL tail_total: got %0d want 1330", wr_cnt - wb); end
    if (wr_cnt - w5 == 50) begin
      compared++;
      if (wr_log[wr_cnt-1] !== 16'h0531) begin
        mismatched++; $display("FAIL tail_last: got %0h want 0531", wr_log[wr_cnt-1]);
      end
    end
  endtask

  task automatic test_loop();
    int w, tb;
    tb = te_cnt;
    do_trig(32'd2048, 1'b1, 32'd200);
    for (int i = 0; i < 4; i++) serve_expect("loop_lba", i);
    w = wr_cnt;
    serve_expect("loop_wrap_lba", 1);
    compared++;
    if (wr_cnt - w !== 112) begin mismatched++; $display("FAIL loop_words: got %0d want 112", wr_cnt - w); end
    if (wr_cnt - w > 0) begin
      compared++;
      if (wr_log[w] !== 16'h0190) begin mismatched++; $display("FAIL loop_first: got %0h want 0190", wr_log[w]); end
    end
`ifdef MSU_LOOP_COUNT_EN
    compared++;
    if (loop_count !== 8'd1) begin mismatched++; $display("FAIL loop_count: got %0d want 1", loop_count); end
`endif
    stop = 1'b1; tick(); stop = 1'b0; tick(2);
    compared++;
    if (playing !== 1'b0 || sd_rd !== 1'b0 || te_cnt != tb) begin
      mismatched++;
      $display("FAIL loop_stop: playing %0b rd %0b te %0d want 0 0 0", playing, sd_rd, te_cnt - tb);
    end
  endtask

  task automatic test_backpressure();
    int n, tb; bit any_rd;
    tb = te_cnt;
    fifo_usedw = 11'd1792;
    do_trig(32'd2048, 1'b0, 32'd0);
    serve_expect("bp_lba", 0);
    any_rd = 1'b0;
    for (int i = 0; i < 10; i++) begin any_rd |= sd_rd; tick(); end
    compared++;
    if (any_rd) begin mismatched++; $display("FAIL bp_hold: sd_rd seen 1 want 0"); end
    fifo_usedw = 11'd1791;
    n = 0;
    while (sd_rd !== 1'b1 && n < 5) begin tick(); n++; end
    compared++;
    if (sd_rd !== 1'b1 || n > 2 || sd_lba !== 21'd1) begin
      mismatched++; $display("FAIL bp_release: cycles %0d lba %0d want <=2 and 1", n, sd_lba);
    end
    fifo_usedw = '0;
    for (int i = 1; i < 4; i++) serve_expect("bp_lba", i);
    tick(4);
    compared++;
    if (te_cnt - tb !== 1) begin mismatched++; $display("FAIL bp_track_end: got %0d want 1", te_cnt - tb); end
  endtask

  task automatic test_stop();
    int w, tb; bit any_rd; logic [20:0] lba; bit ok;
    tb = te_cnt;
    do_trig(32'd2048, 1'b0, 32'd0);
    serve_expect("stop_lba", 0);
    serve_expect("stop_lba", 1);
    w = wr_cnt;
    sd_serve(100, lba, ok);
    compared++;
    if (!ok || lba !== 21'd2 || wr_cnt - w !== 100) begin
      mismatched++; $display("FAIL stop_words: ok %0d lba %0d writes %0d want 1 2 100", ok, lba, wr_cnt - w);
    end
    w = wr_cnt; any_rd = 1'b0;
    for (int i = 0; i < 20; i++) begin any_rd |= sd_rd; tick(); end
    compared++;
    if (any_rd || wr_cnt != w || playing !== 1'b0 || te_cnt != tb) begin
      mismatched++;
      $display("FAIL stop_idle: rd %0b writes %0d playing %0b te %0d want 0 0 0 0",
               any_rd, wr_cnt - w, playing, te_cnt - tb);
    end
  endtask

  task automatic test_zero_size();
    int tb;
    tb = te_cnt;
    do_trig(32'd0, 1'b0, 32'd0);
    compared++;
    if (track_end !== 1'b1 || playing !== 1'b0) begin
      mismatched++; $display("FAIL zero_pulse: te %0b playing %0b want 1 0", track_end, playing);
    end
    tick();
    compared++;
    if (track_end !== 1'b0 || te_cnt - tb !== 1 || sd_rd !== 1'b0) begin
      mismatched++; $display("FAIL zero_after: te %0b count %0d rd %0b want 0 1 0", track_end, te_cnt - tb, sd_rd);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int t;
    do_trig(32'd2048, 1'b0, 32'd0);
    t = 0;
    while (sd_rd !== 1'b1 && t < 100) begin tick(); t++; end
    sd_ack = 1'b1; tick();
    for (int w = 0; w < 10; w++) begin
      sd_buff_wr = 1'b1; sd_buff_dout = 16'h7700 | 16'(w); tick();
    end
    compared++;
    if (fifo_wr !== 1'b1 || playing !== 1'b1) begin
      mismatched++; $display("FAIL rst_pre: wr %0b playing %0b want 1 1", fifo_wr, playing);
    end
    #3 reset_n = 1'b0;
    #1;
    compared++;
    if ({sd_lba, sd_rd, fifo_wr, fifo_data, playing, track_end} !== '0) begin
      mismatched++;
      $display("FAIL rst_async: lba=%0h rd=%0b wr=%0b data=%0h play=%0b te=%0b want all 0",
               sd_lba, sd_rd, fifo_wr, fifo_data, playing, track_end);
    end
    sd_buff_wr = 1'b0; sd_ack = 1'b0;
    tick(2); reset_n = 1'b1; tick(3);
    compared++;
    if (fifo_wr !== 1'b0 || sd_rd !== 1'b0 || playing !== 1'b0) begin
      mismatched++; $display("FAIL rst_idle: wr %0b rd %0b playing %0b want 0 0 0", fifo_wr, sd_rd, playing);
    end
  endtask

  initial begin
    test_reset();
    test_full_track();
    test_partial_tail();
    test_loop();
    test_backpressure();
    test_stop();
    test_zero_size();
    test_reset_mid_xfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/msu_audio_streamer.md
Name: msu_audio_streamer

Overview:
- Parametrised successor to the MSU audio sector fetcher.
- Streams an MSU audio track from the SD sector interface into the audio sample FIFO.
- Supports configurable sector size, data width and LBA width, correct partial final sector trimming, sample-accurate loop points (frame plus word offset), explicit stop, and FIFO back-pressure.
- Sits between the HPS SD block-read handshake and the audio output FIFO.

Parameters:
- SECTOR_LOG2, 9: log2 of bytes per sector (512).
- DATA_W, 16: SD buffer word width; bytes/word = DATA_W/8.
- LBA_W, 21: width of sector address.
- SIZE_W, 32: width of img_size.
- LVL_W, 11: width of fifo_usedw.
- FIFO_HIGH, 1792: a new sector is requested only when fifo_usedw < FIFO_HIGH.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- trig_play  in  1  one-cycle start pulse; restarts playback from frame 0.
- repeat_en  in  1  sampled on trig_play; 1 = loop at end, 0 = stop at end.
- loop_sample  in  32  loop point in 4-byte stereo samples; sampled on trig_play.
- img_size  in  SIZE_W  track size in bytes; sampled on trig_play.
- track_ready  in  1  level; track mounted, fetching may begin.
- stop  in  1  one-cycle stop request.
- sd_lba  out  LBA_W  sector address for the current request.
- sd_rd  out  1  read request.
- sd_ack  in  1  high for the duration of a sector transfer.
- sd_buff_wr  in  1  word strobe during sd_ack.
- sd_buff_dout  in  DATA_W  sector word.
- fifo_wr  out  1  write strobe to the audio FIFO.
- fifo_data  out  DATA_W  word to the FIFO.
- fifo_usedw  in  LVL_W  FIFO fill level.
- playing  out  1  playback active.
- track_end  out  1  one-cycle pulse when a non-repeating track finishes or img_size==0.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-transfer abandons the sector; no further fifo_wr.
- Derived on trig_play (registered):
  - WPS = 2^SECTOR_LOG2 / (DATA_W/8).
  - end_frame = ceil(img_size / 2^SECTOR_LOG2) - 1.
  - tail_words = (img_size mod 2^SECTOR_LOG2) / (DATA_W/8); value 0 means full sector.
  - loop_byte = loop_sample*4; loop_frame = loop_byte >> SECTOR_LOG2; loop_word = (loop_byte mod sector) / (DATA_W/8).
  - If loop_frame > end_frame, the loop point becomes frame 0, word 0.
- States:
  - IDLE: wait for trig_play.
  - MOUNT: wait for track_ready.
  - REQ: sd_lba = frame, sd_rd = 1.
  - XFER: sd_rd drops on the first cycle sd_ack is high; count words on sd_buff_wr.
  - NEXT: decide the next action.
- trig_play always wins: from any state it clears frame to 0, latches the inputs, and enters MOUNT with playing = 1.
  - If img_size == 0: go to IDLE instead, playing = 0, track_end pulses 1 cycle later.
  - A trig_play during XFER continues counting sd_buff_wr until sd_ack falls, writes nothing, then enters MOUNT.
- MOUNT -> REQ when track_ready = 1.
- XFER forwarding: word index w forwards sd_buff_dout to fifo_wr/fifo_data one cycle after the strobe, subject to two rules:
  - On the final frame with tail_words != 0, only w < tail_words are forwarded.
  - On the first frame after a loop wrap, only w >= loop_word are forwarded.
  - Both rules apply when loop_frame == end_frame.
- XFER -> NEXT when sd_ack falls.
- NEXT:
  - Waits while fifo_usedw >= FIFO_HIGH.
  - If frame < end_frame: frame + 1, then REQ.
  - Else if repeat: frame = loop_frame, set wrap flag, then REQ.
  - Else: playing = 0, track_end pulse, then IDLE.
- stop:
  - In IDLE/MOUNT/REQ/NEXT: go to IDLE immediately with playing = 0.
  - In XFER: suppress further fifo_wr, drain until sd_ack falls, then IDLE.
  - No track_end pulse on stop.
- trig_play and stop in the same cycle: trig_play wins.
- Frame arithmetic is LBA_W wide; img_size bits above LBA_W+SECTOR_LOG2 are ignored.

Optional Feature:
- MSU_LOOP_COUNT_EN.
- Defined: adds output loop_count [7:0]. It is cleared on trig_play, increments on each loop wrap, and saturates at 255.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package msu_pkg: state enum (IDLE, MOUNT, REQ, XFER, NEXT), BYTES_PER_SAMPLE = 4, and a function computing end_frame/tail_words from size and SECTOR_LOG2.
- One sub-module msu_word_gate: combinational plus registered word-index window filter (lo/hi bounds -> fifo_wr).

Test Plan:
- img_size = 2048, repeat = 0, track_ready = 1: LBAs 0,1,2,3 requested; 1024 fifo_wr; track_end pulses once; playing = 0.
- img_size = 2560 + 100 = 2660, repeat = 0: LBAs 0..5; LBA 5 forwards exactly 50 words; total 1330 fifo_wr.
- img_size = 2048, repeat = 1, loop_sample = 200 (byte 800): after LBA 3, LBA 1 is requested and its first forwarded word is index 144; with MSU_LOOP_COUNT_EN, loop_count = 1.
- fifo_usedw held at 1792 after LBA 0: no sd_rd while held; the request for LBA 1 is issued within 2 cycles of dropping to 1791.
- stop asserted at word 100 of LBA 2: no fifo_wr after that cycle; sd_rd stays 0; IDLE after sd_ack falls; no track_end.
- img_size = 0 trig_play -> playing stays 0, track_end pulses 1 cycle after; reset_n low mid-XFER -> all outputs 0 asynchronously.
